ctrl_sequencer: RTL and testbench

- Multi-cycle control sequencer for the 3-bit-opcode accumulator CPU. It sits directly upstream of the branch decision logic.
- Steps through fetch/decode/execute and emits one-cycle control strobes to the PC, MAR, IR, memory, ALU/accumulator and flags register.
- Drives ctrl_jmp_o, the enable the branch stage ANDs with its jump/zero/carry decode.
- ISA (op = instruction[7:5]): 000 ADD, 001 SUB, 010 LDA, 011 STA, 100 JMP, 101 JZ, 110 JC, 111 HLT.

---
 rtl/ctrl_sequencer.sv | 141 ++++++++++++++
 tb/tb_ctrl_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute control sequencer for the 3-bit-opcode accumulator CPU.
// Strobes are a combinational decode of the state register (ir_op_i in D, latched op_q in E0/E1).
module ctrl_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [2:0]       ir_op_i,
    output logic [2:0]       state_o,
    output logic             ctrl_mar_pc_o,
    output logic             ctrl_mar_ir_o,
    output logic             ctrl_mem_rd_o,
    output logic             ctrl_mem_wr_o,
    output logic             ctrl_pc_inc_o,
    output logic             ctrl_ir_load_o,
    output logic             ctrl_acc_load_o,
    output logic [1:0]       ctrl_alu_op_o,
    output logic             ctrl_flags_load_o,
    output logic             ctrl_jmp_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        F0   = 3'd1,
        F1   = 3'd2,
        F2   = 3'd3,
        D    = 3'd4,
        E0   = 3'd5,
        E1   = 3'd6,
        HALT = 3'd7
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_JZ  = 3'b101;
    localparam logic [2:0] OP_JC  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    state_t     state;
    state_t     next;
    logic [2:0] op_q;
    logic       retire;

    assign state_o = state;

    always_comb begin
        next              = state;
        retire            = 1'b0;
        ctrl_mar_pc_o     = 1'b0;
        ctrl_mar_ir_o     = 1'b0;
        ctrl_mem_rd_o     = 1'b0;
        ctrl_mem_wr_o     = 1'b0;
        ctrl_pc_inc_o     = 1'b0;
        ctrl_ir_load_o    = 1'b0;
        ctrl_acc_load_o   = 1'b0;
        ctrl_alu_op_o     = 2'b00;
        ctrl_flags_load_o = 1'b0;
        ctrl_jmp_o        = 1'b0;
        halted_o          = 1'b0;
        case (state)
            IDLE: next = run_i ? F0 : IDLE;
            F0: begin
                ctrl_mar_pc_o = 1'b1;
                next          = F1;
            end
            F1: begin
                ctrl_mem_rd_o = 1'b1;
                ctrl_pc_inc_o = 1'b1;
                next          = F2;
            end
            F2: begin
                ctrl_ir_load_o = 1'b1;
                next           = D;
            end
            D: begin
                case (ir_op_i)
                    OP_ADD, OP_SUB, OP_LDA, OP_STA: begin
                        ctrl_mar_ir_o = 1'b1;
                        next          = E0;
                    end
                    OP_JMP, OP_JZ, OP_JC: begin
                        // Branch stage owns the taken decision; we only enable it.
                        ctrl_jmp_o = 1'b1;
                        retire     = 1'b1;
                        next       = run_i ? F0 : IDLE;
                    end
                    OP_HLT: begin
                        retire = 1'b1;
                        next   = HALT;
                    end
                    default: next = IDLE;
                endcase
            end
            E0: begin
                if (op_q == OP_STA) begin
                    ctrl_mem_wr_o = 1'b1;
                    retire        = 1'b1;
                    next          = run_i ? F0 : IDLE;
                end else begin
                    ctrl_mem_rd_o = 1'b1;
                    next          = E1;
                end
            end
            E1: begin
                ctrl_acc_load_o = 1'b1;
                case (op_q)
                    OP_ADD:  ctrl_alu_op_o = 2'b01;
                    OP_SUB:  ctrl_alu_op_o = 2'b10;
                    default: ctrl_alu_op_o = 2'b00;
                endcase
                // LDA must not disturb Z/C.
                ctrl_flags_load_o = (op_q == OP_ADD) || (op_q == OP_SUB);
                retire            = 1'b1;
                next              = run_i ? F0 : IDLE;
            end
            HALT: halted_o = 1'b1;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            op_q        <= 3'b000;
            instr_cnt_o <= '0;
        end else begin
            state <= next;
            if (state == D)
                op_q <= ir_op_i;
            if (retire && (instr_cnt_o != {CNT_W{1'b1}}))
                instr_cnt_o <= instr_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized self-checking bench for ctrl_sequencer: per-instruction cycle tables built from
// the ISA timing rules, replayed cycle by cycle against a 16-bit and a 2-bit-counter instance.
module tb_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [2:0] op  = 3'b000;

    logic [2:0]  st, st2;
    logic        mar_pc, mar_ir, mem_rd, mem_wr, pc_inc, ir_load, acc_load, flags_load, jmp, halted;
    logic        mar_pc2, mar_ir2, mem_rd2, mem_wr2, pc_inc2, ir_load2, acc_load2, flags_load2, jmp2, halted2;
    logic [1:0]  alu_op, alu_op2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic [14:0] obs, obs2;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ctrl_sequencer #(.CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .ir_op_i(op), .state_o(st),
        .ctrl_mar_pc_o(mar_pc), .ctrl_mar_ir_o(mar_ir), .ctrl_mem_rd_o(mem_rd),
        .ctrl_mem_wr_o(mem_wr), .ctrl_pc_inc_o(pc_inc), .ctrl_ir_load_o(ir_load),
        .ctrl_acc_load_o(acc_load), .ctrl_alu_op_o(alu_op), .ctrl_flags_load_o(flags_load),
        .ctrl_jmp_o(jmp), .halted_o(halted), .instr_cnt_o(cnt)
    );

    ctrl_sequencer #(.CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .run_i(run), .ir_op_i(op), .state_o(st2),
        .ctrl_mar_pc_o(mar_pc2), .ctrl_mar_ir_o(mar_ir2), .ctrl_mem_rd_o(mem_rd2),
        .ctrl_mem_wr_o(mem_wr2), .ctrl_pc_inc_o(pc_inc2), .ctrl_ir_load_o(ir_load2),
        .ctrl_acc_load_o(acc_load2), .ctrl_alu_op_o(alu_op2), .ctrl_flags_load_o(flags_load2),
        .ctrl_jmp_o(jmp2), .halted_o(halted2), .instr_cnt_o(cnt2)
    );

    assign obs  = {st, mar_pc, mar_ir, mem_rd, mem_wr, pc_inc, ir_load, acc_load,
                   alu_op, flags_load, jmp, halted};
    assign obs2 = {st2, mar_pc2, mar_ir2, mem_rd2, mem_wr2, pc_inc2, ir_load2, acc_load2,
                   alu_op2, flags_load2, jmp2, halted2};

    // One scheduled cycle: what to drive and what must be seen during that cycle.
    typedef struct {
        logic [2:0]  op;
        logic        run;
        logic        rst;
        logic        chk;
        logic [14:0] ev;
        int          cnt;
        int          cnt2;
    } step_t;

    step_t sq[$];
    int    cnt_m, cnt2_m;

    // Expected vector: state, then {mar_pc,mar_ir,rd,wr,inc,irl,accl,alu[1:0],flags,jmp,halt}.
    function automatic logic [14:0] ev(input int s, input logic [11:0] b);
        return {3'(s), b};
    endfunction

    function automatic logic [2:0] rnd_op();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic void push(input logic [2:0] o, input logic r, input logic rs,
                                 input logic c, input logic [14:0] e);
        step_t s;
        s.op = o; s.run = r; s.rst = rs; s.chk = c; s.ev = e; s.cnt = cnt_m; s.cnt2 = cnt2_m;
        sq.push_back(s);
    endfunction

    // Reset for one cycle, then one IDLE cycle with run=1 so the next step is F0.
    function automatic void add_reset();
        push(rnd_op(), 1'b0, 1'b1, 1'b0, '0);
        cnt_m = 0; cnt2_m = 0;
        push(rnd_op(), 1'b1, 1'b0, 1'b1, '0);
    endfunction

    function automatic void add_idle(input int n, input logic run_last);
        for (int k = 0; k < n; k++)
            push(rnd_op(), (k == n - 1) ? run_last : 1'b0, 1'b0, 1'b1, '0);
    endfunction

    // Cycle table of one instruction from F0 to its retire cycle; run is only honoured at retire.
    function automatic void add_instr(input logic [2:0] o, input logic run_after);
        logic [14:0] v[$];
        logic [1:0]  alu;
        v.push_back(ev(1, 12'b1_0_0_0_0_0_0_00_0_0_0));
        v.push_back(ev(2, 12'b0_0_1_0_1_0_0_00_0_0_0));
        v.push_back(ev(3, 12'b0_0_0_0_0_1_0_00_0_0_0));
        if (o <= 3)       v.push_back(ev(4, 12'b0_1_0_0_0_0_0_00_0_0_0));
        else if (o == 7)  v.push_back(ev(4, 12'b0));
        else              v.push_back(ev(4, 12'b0_0_0_0_0_0_0_00_0_1_0));
        if (o <= 2) begin
            alu = (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00;
            v.push_back(ev(5, 12'b0_0_1_0_0_0_0_00_0_0_0));
            v.push_back(ev(6, {7'b0000001, alu, (o != 2), 2'b00}));
        end else if (o == 3) begin
            v.push_back(ev(5, 12'b0_0_0_1_0_0_0_00_0_0_0));
        end
        foreach (v[i])
            push((i == 3) ? o : rnd_op(),
                 (i == v.size() - 1) ? run_after : 1'($urandom_range(0, 1)), 1'b0, 1'b1, v[i]);
        cnt_m  = (cnt_m == 65535) ? cnt_m : cnt_m + 1;
        cnt2_m = (cnt2_m == 3) ? 3 : cnt2_m + 1;
    endfunction

    function automatic void add_halt(input int n);
        for (int k = 0; k < n; k++)
            push(rnd_op(), 1'b1, 1'b0, 1'b1, ev(7, 12'b0_0_0_0_0_0_0_00_0_0_1));
    endfunction

    task automatic tick(input logic [2:0] o, input logic r, input logic rs);
        @(posedge clk);
        #1;
        op = o; run = r; rst = rs;
        #1;
    endtask

    task automatic test_reset();
        sq = {};
        push(rnd_op(), 1'b0, 1'b1, 1'b0, '0);
        push(rnd_op(), 1'b0, 1'b1, 1'b0, '0);
        cnt_m = 0; cnt2_m = 0;
        add_idle(5, 1'b0);
        foreach (sq[i]) begin
            tick(sq[i].op, sq[i].run, sq[i].rst);
            if (sq[i].chk) begin
                tests++;
                if ({obs, obs2, cnt, cnt2} !== {sq[i].ev, sq[i].ev, 16'(sq[i].cnt), 2'(sq[i].cnt2)}) begin
                    failed++;
                    $display("FAIL reset step%0d: got out=%h out2=%h cnt=%0d cnt2=%0d want out=%h cnt=%0d",
                             i, obs, obs2, cnt, cnt2, sq[i].ev, sq[i].cnt);
                end
            end
        end
    endtask

    task automatic test_lda();
        sq = {};
        add_reset();
        add_instr(3'b010, 1'b1);
        push(rnd_op(), 1'b0, 1'b0, 1'b1, ev(1, 12'b1_0_0_0_0_0_0_00_0_0_0));
        foreach (sq[i]) begin
            tick(sq[i].op, sq[i].run, sq[i].rst);
            if (sq[i].chk) begin
                tests++;
                if ({obs, obs2, cnt, cnt2} !== {sq[i].ev, sq[i].ev, 16'(sq[i].cnt), 2'(sq[i].cnt2)}) begin
                    failed++;
                    $display("FAIL lda step%0d: got out=%h cnt=%0d cnt2=%0d want out=%h cnt=%0d",
                             i, obs, cnt, cnt2, sq[i].ev, sq[i].cnt);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        sq = {};
        add_reset();
        add_instr(3'b001, 1'b1);
        add_instr(3'b011, 1'b1);
        add_instr(3'b101, 1'b1);
        add_instr(3'b000, 1'b0);
        add_idle(2, 1'b0);
        foreach (sq[i]) begin
            tick(sq[i].op, sq[i].run, sq[i].rst);
            if (sq[i].chk) begin
                tests++;
                if ({obs, obs2, cnt, cnt2} !== {sq[i].ev, sq[i].ev, 16'(sq[i].cnt), 2'(sq[i].cnt2)}) begin
                    failed++;
                    $display("FAIL b2b step%0d: got out=%h cnt=%0d cnt2=%0d want out=%h cnt=%0d",
                             i, obs, cnt, cnt2, sq[i].ev, sq[i].cnt);
                end
            end
        end
    endtask

    task automatic test_mid_instr();
        int e0;
        sq = {};
        add_reset();
        // ADD with run dropped in E0/E1: must finish, then go idle.
        e0 = sq.size() + 4;
        add_instr(3'b000, 1'b0);
        sq[e0].run = 1'b0;
        add_idle(2, 1'b1);
        // ADD aborted by reset in E0: next cycle idle, counter cleared, no read.
        e0 = sq.size() + 4;
        add_instr(3'b000, 1'b1);
        void'(sq.pop_back());
        sq[e0].rst = 1'b1;
        cnt_m = 0; cnt2_m = 0;
        add_idle(3, 1'b0);
        foreach (sq[i]) begin
            tick(sq[i].op, sq[i].run, sq[i].rst);
            if (sq[i].chk) begin
                tests++;
                if ({obs, obs2, cnt, cnt2} !== {sq[i].ev, sq[i].ev, 16'(sq[i].cnt), 2'(sq[i].cnt2)}) begin
                    failed++;
                    $display("FAIL mid_instr step%0d: got out=%h cnt=%0d cnt2=%0d want out=%h cnt=%0d",
                             i, obs, cnt, cnt2, sq[i].ev, sq[i].cnt);
                end
            end
        end
    endtask

    task automatic test_halt();
        sq = {};
        add_reset();
        add_instr(3'b100, 1'b1);
        add_instr(3'b111, 1'b1);
        add_halt(10);
        foreach (sq[i]) begin
            tick(sq[i].op, sq[i].run, sq[i].rst);
            if (sq[i].chk) begin
                tests++;
                if ({obs, obs2, cnt, cnt2} !== {sq[i].ev, sq[i].ev, 16'(sq[i].cnt), 2'(sq[i].cnt2)}) begin
                    failed++;
                    $display("FAIL halt step%0d: got out=%h cnt=%0d cnt2=%0d want out=%h cnt=%0d",
                             i, obs, cnt, cnt2, sq[i].ev, sq[i].cnt);
                end
            end
        end
    endtask

    task automatic test_saturation();
        sq = {};
        add_reset();
        for (int k = 0; k < 5; k++)
            add_instr(3'b100, (k != 4));
        add_idle(1, 1'b0);
        foreach (sq[i]) begin
            tick(sq[i].op, sq[i].run, sq[i].rst);
            if (sq[i].chk) begin
                tests++;
                if ({obs, obs2, cnt, cnt2} !== {sq[i].ev, sq[i].ev, 16'(sq[i].cnt), 2'(sq[i].cnt2)}) begin
                    failed++;
                    $display("FAIL saturation step%0d: got out=%h cnt=%0d cnt2=%0d want out=%h cnt=%0d cnt2=%0d",
                             i, obs, cnt, cnt2, sq[i].ev, sq[i].cnt, sq[i].cnt2);
                end
            end
        end
        tests++;
        if (cnt2 !== 2'd3 || cnt !== 16'd5) begin
            failed++;
            $display("FAIL saturation_final: got cnt=%0d cnt2=%0d want cnt=5 cnt2=3", cnt, cnt2);
        end
    endtask

    task automatic test_random();
        logic r;
        sq = {};
        add_reset();
        for (int k = 0; k < 40; k++) begin
            r = 1'($urandom_range(0, 1));
            add_instr(3'($urandom_range(0, 6)), r);
            if (!r)
                add_idle($urandom_range(1, 3), 1'b1);
        end
        add_instr(3'($urandom_range(0, 6)), 1'b0);
        add_idle(1, 1'b0);
        foreach (sq[i]) begin
            tick(sq[i].op, sq[i].run, sq[i].rst);
            if (sq[i].chk) begin
                tests++;
                if ({obs, obs2, cnt, cnt2} !== {sq[i].ev, sq[i].ev, 16'(sq[i].cnt), 2'(sq[i].cnt2)}) begin
                    failed++;
                    $display("FAIL random step%0d: got out=%h cnt=%0d cnt2=%0d want out=%h cnt=%0d",
                             i, obs, cnt, cnt2, sq[i].ev, sq[i].cnt);
                end
                tests++;
                if ((mar_pc && mar_ir) || (mem_rd && mem_wr)) begin
                    failed++;
                    $display("FAIL random_exclusive step%0d: got mar_pc=%b mar_ir=%b rd=%b wr=%b want no overlap",
                             i, mar_pc, mar_ir, mem_rd, mem_wr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_back_to_back();
        test_mid_instr();
        test_halt();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
